// File: rtl/upload_arbiter.sv
// Multi-channel upload merger: per-channel byte FIFOs feeding one ready/valid byte stream.
// Round-robin bursts, optionally framed as {0xA, channel}, length, payload.
module upload_arbiter #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BURST_MAX  = 8,
    parameter int unsigned HEADER_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH*8-1:0]   ch_data,
    input  logic [NUM_CH-1:0]     ch_valid,
    input  logic [NUM_CH-1:0]     ovf_clear,
    output logic [NUM_CH-1:0]     ch_overflow,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_LEN  = 2'd2;
    localparam logic [1:0] S_DATA = 2'd3;

    logic [7:0]       mem    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr [NUM_CH];
    logic [PTR_W-1:0] rd_ptr [NUM_CH];
    logic [CNT_W-1:0] count  [NUM_CH];
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] pop;

    logic [1:0]      state, state_nxt;
    logic [CH_W-1:0] grant, grant_nxt;
    logic [CH_W-1:0] last_grant, last_grant_nxt;
    logic [7:0]      burst_len, burst_len_nxt;
    logic [7:0]      sent, sent_nxt;
    logic            out_valid_nxt;
    logic [7:0]      out_data_nxt;

    logic            found;
    logic [CH_W-1:0] sel;
    logic [CNT_W-1:0] avail;
    logic [7:0]      sel_len;
    logic [7:0]      head_sel;
    logic [7:0]      head_g;
    logic [7:0]      next_g;
    logic            xfer;

    // Writes only land when the FIFO has room before this edge's pop.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            wr_en[i] = ch_valid[i] && (count[i] != CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (wr_en[i]) begin
                mem[i][wr_ptr[i]] <= ch_data[8*i +: 8];
            end
        end
    end

    // Pointers, occupancy and sticky overflow (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            ch_overflow <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (wr_en[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i] <= count[i] + CNT_W'(wr_en[i]) - CNT_W'(pop[i]);
                if (ch_valid[i] && !wr_en[i]) begin
                    ch_overflow[i] <= 1'b1;
                end else if (ovf_clear[i]) begin
                    ch_overflow[i] <= 1'b0;
                end
            end
        end
    end

    // Round-robin search starting just after the last completed grant.
    always_comb begin : arb_search
        int idx;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            idx = int'(last_grant) + 1 + k;
            if (idx >= int'(NUM_CH)) begin
                idx = idx - int'(NUM_CH);
            end
            if (!found && (count[idx] != '0)) begin
                found = 1'b1;
                sel   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        avail    = count[sel];
        sel_len  = (32'(avail) > BURST_MAX) ? 8'(BURST_MAX) : 8'(avail);
        head_sel = mem[sel][rd_ptr[sel]];
        head_g   = mem[grant][rd_ptr[grant]];
        next_g   = mem[grant][rd_ptr[grant] + PTR_W'(1)];
        xfer     = out_valid && out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
            burst_len  <= '0;
            sent       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            burst_len  <= burst_len_nxt;
            sent       <= sent_nxt;
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
        end
    end

    // out_data is registered, so each transfer preloads the next byte of the frame.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        burst_len_nxt  = burst_len;
        sent_nxt       = sent;
        out_valid_nxt  = out_valid;
        out_data_nxt   = out_data;
        pop            = '0;
        case (state)
            S_IDLE: begin
                out_valid_nxt = 1'b0;
                if (found) begin
                    grant_nxt     = sel;
                    burst_len_nxt = sel_len;
                    sent_nxt      = '0;
                    out_valid_nxt = 1'b1;
                    if (HEADER_EN != 0) begin
                        state_nxt    = S_HDR;
                        out_data_nxt = {4'hA, 4'(sel)};
                    end else begin
                        state_nxt    = S_DATA;
                        out_data_nxt = head_sel;
                    end
                end
            end
            S_HDR: begin
                if (xfer) begin
                    state_nxt    = S_LEN;
                    out_data_nxt = burst_len;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    state_nxt    = S_DATA;
                    out_data_nxt = head_g;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    pop[grant] = 1'b1;
                    if (sent + 8'd1 == burst_len) begin
                        state_nxt      = S_IDLE;
                        out_valid_nxt  = 1'b0;
                        last_grant_nxt = grant;
                    end else begin
                        sent_nxt     = sent + 8'd1;
                        out_data_nxt = next_g;
                    end
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                out_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_upload_arbiter.sv
// Directed bench for upload_arbiter: framed 4-channel instance plus a raw 2-channel instance.
module tb_upload_arbiter;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid, ovf_clear, ch_overflow;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;

    logic [15:0] b_data;
    logic [1:0]  b_valid, b_clr, b_ovf;
    logic [7:0]  b_out;
    logic        b_ov, b_rdy;

    upload_arbiter #(.NUM_CH(4), .FIFO_DEPTH(16), .BURST_MAX(8), .HEADER_EN(1)) dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .ch_valid(ch_valid), .ovf_clear(ovf_clear),
        .ch_overflow(ch_overflow), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    upload_arbiter #(.NUM_CH(2), .FIFO_DEPTH(16), .BURST_MAX(8), .HEADER_EN(0)) dut_b (
        .clk(clk), .rst(rst), .ch_data(b_data), .ch_valid(b_valid), .ovf_clear(b_clr),
        .ch_overflow(b_ovf), .out_data(b_out), .out_valid(b_ov), .out_ready(b_rdy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transfer capture and stall-hold check for the framed instance.
    bq_t        q;
    int         tq[$];
    int         cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bq_t        qb;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (prev_stall && out_valid) check("stall_hold", out_data, prev_data);
            if (out_valid && out_ready) begin
                q.push_back(out_data);
                tq.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (b_ov && b_rdy) qb.push_back(b_out);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [3:0] mask, input logic [31:0] data);
        ch_valid = mask;
        ch_data  = data;
        tick();
        ch_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        q.delete();
        tq.delete();
    endtask

    task automatic drain_a(input int max_cyc);
        int idle = 0;
        int n = 0;
        while (idle < 3 && n < max_cyc) begin
            tick();
            n++;
            idle = out_valid ? 0 : idle + 1;
        end
        check("drain_done", 32'(idle >= 3), 1);
    endtask

    task automatic check_stream(input string tag, input bq_t exp);
        check({tag, "_len"}, q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < q.size()) check($sformatf("%s[%0d]", tag, i), q[i], exp[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t e;
        rst = 1'b0; ch_data = '0; ch_valid = '0; ovf_clear = '0; out_ready = 1'b0;
        b_data = '0; b_valid = '0; b_clr = '0; b_rdy = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ovf", ch_overflow, 0);
        tick();
        tick();
        rst = 1'b0;

        // First write latency, then a 3-byte ch2 burst queued behind a stalled ch0 frame.
        write_a(4'b0001, 32'h0000_00E0);
        check("lat_idle", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_hdr", out_data, 8'hA0);
        write_a(4'b0100, 32'h0011_0000);
        write_a(4'b0100, 32'h0022_0000);
        write_a(4'b0100, 32'h0033_0000);
        out_ready = 1'b1;
        drain_a(100);
        e = {8'hA0, 8'h01, 8'hE0, 8'hA2, 8'h03, 8'h11, 8'h22, 8'h33};
        check_stream("ch2_burst", e);
        if (tq.size() >= 4) check("gap_one_idle", tq[3] - tq[2], 2);
        check("ch2_idle_valid", out_valid, 0);

        // Overflow on ch0: 20 writes into 16 slots, set-wins, clear, then two 8-byte bursts.
        do_reset();
        out_ready = 1'b0;
        write_a(4'b0010, 32'h0000_5500);
        tick();
        for (int k = 0; k < 20; k++) write_a(4'b0001, 32'(48 + k));
        check("ovf_set", ch_overflow, 4'b0001);
        ch_valid = 4'b0001; ch_data = 32'h0000_0099; ovf_clear = 4'b0001;
        tick();
        ch_valid = '0; ovf_clear = '0;
        check("ovf_set_wins", ch_overflow, 4'b0001);
        ovf_clear = 4'b0001;
        tick();
        ovf_clear = '0;
        check("ovf_clear", ch_overflow, 4'b0000);
        out_ready = 1'b1;
        drain_a(100);
        e = {8'hA1, 8'h01, 8'h55, 8'hA0, 8'h08};
        for (int i = 0; i < 8; i++) e.push_back(8'(48 + i));
        e.push_back(8'hA0);
        e.push_back(8'h08);
        for (int i = 8; i < 16; i++) e.push_back(8'(48 + i));
        check_stream("ovf_bursts", e);

        // Simultaneous channels: ch3 parked first, then 0,1,3 served in round-robin order.
        do_reset();
        out_ready = 1'b0;
        write_a(4'b1000, 32'hF000_0000);
        tick();
        write_a(4'b1011, 32'h3100_1101);
        write_a(4'b1011, 32'h3200_1202);
        out_ready = 1'b1;
        drain_a(100);
        e = {8'hA3, 8'h01, 8'hF0, 8'hA0, 8'h02, 8'h01, 8'h02,
             8'hA1, 8'h02, 8'h11, 8'h12, 8'hA3, 8'h02, 8'h31, 8'h32};
        check_stream("round_robin", e);

        // Random backpressure; the burst length is frozen at grant time.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) write_a(4'b0010, 32'(8'h81 + k) << 8);
        begin
            int n = 0;
            while (q.size() < 12 && n < 300) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
        end
        out_ready = 1'b1;
        drain_a(50);
        e = {8'hA1, 8'h01, 8'h81, 8'hA1, 8'h07};
        for (int i = 1; i < 8; i++) e.push_back(8'(8'h81 + i));
        check_stream("backpressure", e);

        // Reset while byte 2 of a 4-byte payload is stalled on the port.
        do_reset();
        out_ready = 1'b0;
        write_a(4'b0001, 32'h0000_00E5);
        tick();
        for (int k = 0; k < 4; k++) write_a(4'b0010, 32'(8'h91 + k) << 8);
        out_ready = 1'b1;
        begin
            int n = 0;
            while (q.size() < 6 && n < 100) begin
                tick();
                n++;
            end
        end
        out_ready = 1'b0;
        check("mid_valid", out_valid, 1);
        check("mid_byte2", out_data, 8'h92);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        tick();
        tick();
        rst = 1'b0;
        q.delete();
        tq.delete();
        out_ready = 1'b1;
        repeat (10) tick();
        check("post_rst_quiet", q.size(), 0);
        check("post_rst_valid", out_valid, 0);
        write_a(4'b0100, 32'h0077_0000);
        drain_a(50);
        e = {8'hA2, 8'h01, 8'h77};
        check_stream("post_rst_frame", e);

        // Raw 2-channel instance: ch0 streams every cycle, ch1 injects 5 bytes.
        do_reset();
        qb.delete();
        for (int c = 0; c < 60; c++) begin
            b_valid = {1'(c >= 5 && c < 10), 1'b1};
            b_data  = {8'(188 + c), 8'(c)};
            tick();
        end
        b_valid = '0;
        begin
            int idle = 0;
            int n = 0;
            int run = 0;
            int maxrun = 0;
            int n1 = 0;
            int bad0 = 0;
            int hdr = 0;
            bit first0 = 1'b1;
            logic [7:0] last0 = 8'h00;
            while (idle < 3 && n < 200) begin
                tick();
                n++;
                idle = b_ov ? 0 : idle + 1;
            end
            check("b_drain", 32'(idle >= 3), 1);
            foreach (qb[i]) begin
                if (qb[i][7:4] == 4'hA) hdr++;
                if (qb[i] >= 8'hC0) begin
                    check($sformatf("b_ch1_order%0d", n1), qb[i], 32'(8'hC1 + n1));
                    n1++;
                    if (run > maxrun) maxrun = run;
                    run = 0;
                end else begin
                    if (!first0 && qb[i] <= last0) bad0++;
                    first0 = 1'b0;
                    last0  = qb[i];
                    run++;
                end
            end
            check("b_ch1_count", n1, 5);
            check("b_max_run", 32'(maxrun <= 8), 1);
            check("b_ch0_order", bad0, 0);
            check("b_no_header", hdr, 0);
            if (qb.size() > 0) check("b_first", qb[0], 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upload_arbiter.md
UPLOAD_ARBITER -- requirements
Module: upload_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of upload source channels, range 2..16.
REQ-002 Parameter FIFO_DEPTH, default 16: per-channel FIFO depth in bytes, power of two, range 4..256.
REQ-003 Parameter BURST_MAX, default 8: maximum payload bytes per burst, range 1..FIFO_DEPTH.
REQ-004 Parameter HEADER_EN, default 1: 1 = framed bursts (header + length + payload), 0 = raw payload only.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ch_data  input  NUM_CH*8  per-channel byte; channel i occupies bits [8i+7:8i].
REQ-008 ch_valid  input  NUM_CH  per-channel write strobe, one byte per asserted cycle, no backpressure.
REQ-009 ovf_clear  input  NUM_CH  per-channel clear of the sticky overflow flag.
REQ-010 ch_overflow  output  NUM_CH  sticky flag: a byte was dropped on that channel.
REQ-011 out_data  output  8  merged upload byte toward the USB CDC upload port.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts out_data this cycle.

Function
REQ-014 Each channel SHALL own a FIFO of FIFO_DEPTH bytes with count width clog2(FIFO_DEPTH)+1; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 A write SHALL be accepted when ch_valid[i]=1 and count<FIFO_DEPTH at that edge; a simultaneous read of the same FIFO SHALL NOT make room for it.
REQ-016 A write to a full FIFO SHALL be dropped and SHALL set ch_overflow[i] on the same edge.
REQ-017 ch_overflow[i] SHALL clear on an edge with ovf_clear[i]=1; when set and clear coincide, set SHALL win.
REQ-018 Transfer on out_data SHALL occur on an edge with out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-019 States: IDLE, HDR, LEN, DATA; HDR and LEN SHALL be skipped when HEADER_EN=0.
REQ-020 IDLE: when any FIFO is non-empty, grant the first non-empty channel searching from (last_grant+1) mod NUM_CH upward; after reset, last_grant = NUM_CH-1, so the search starts at channel 0.
REQ-021 At grant, burst length L = min(count[grant], BURST_MAX) SHALL be latched; bytes arriving later SHALL NOT extend the burst.
REQ-022 HDR: out_data = {4'hA, grant[3:0]}; on transfer -> LEN.
REQ-023 LEN: out_data = L (8-bit, BURST_MAX<=255); on transfer -> DATA.
REQ-024 DATA: out_data = head byte of FIFO[grant], popped on transfer; after the L-th transfer -> IDLE, with last_grant updated.
REQ-025 out_valid SHALL go high on the edge following the first write into an empty arbiter, one cycle of latency; out_valid SHALL be 0 in IDLE.
REQ-026 Back-to-back bursts SHALL insert exactly one IDLE cycle between the last DATA transfer and the next header.
REQ-027 Bytes within a channel SHALL leave in write order; a channel SHALL NOT be granted twice in a row while another channel is non-empty.

Reset
REQ-028 On rst=1, all FIFOs SHALL be emptied, state SHALL be IDLE, last_grant SHALL be NUM_CH-1, and out_valid, out_data and ch_overflow SHALL be 0, immediately and independent of clk.
REQ-029 Reset mid-burst SHALL discard the burst; no partial frame completion after rst deasserts.

Verification
REQ-030 Default params; write 3 bytes 0x11,0x22,0x33 on ch2, out_ready=1 -> out stream 0xA2,0x03,0x11,0x22,0x33, then out_valid=0.
REQ-031 Write 20 bytes on ch0 with no out_ready -> 16 stored, ch_overflow[0]=1; then out_ready=1 -> bursts of length 8 and 8; ovf_clear[0] -> flag 0.
REQ-032 Write 2 bytes each on ch0, ch1 and ch3 simultaneously -> headers 0xA0, 0xA1, 0xA3 in that order, each with length 0x02.
REQ-033 Toggle out_ready randomly during a burst -> out_data held stable while stalled; byte order intact; no loss or duplication.
REQ-034 HEADER_EN=0, NUM_CH=2: ch1 gets 5 bytes while ch0 streams continuously -> output alternates, with at most BURST_MAX bytes from ch0 between ch1 bytes, and no header or length bytes.
REQ-035 Assert rst during DATA, byte 2 of 4 -> out_valid=0 asynchronously; after release, no output until new writes.
